// File: rtl/fft_agu.sv
// Address sequencer for an in-place radix-2 DIT FFT over ping-pong RAM banks.
// Optional macro FFT_AGU_STALL_EN adds a stall input that freezes the whole sequencer.
//
// state   | meaning
// S_IDLE  | waiting for start
// S_RUN   | one butterfly read per cycle, idx = butterfly index
// S_DRAIN | reads stopped, waiting BF_LAT cycles for the stage's writes to land
// S_FIN   | one-cycle done pulse
module fft_agu #(
    parameter int bit_width = 16,
    parameter int N         = 32,
    parameter int M         = 5,
    parameter int BF_LAT    = 3
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
`ifdef FFT_AGU_STALL_EN
    input  logic         stall,
`endif
    output logic         busy,
    output logic         done,
    output logic         bank_sel,
    output logic [M-1:0] stage,
    output logic         rd_valid,
    output logic [M-1:0] rd_adr_a,
    output logic [M-1:0] rd_adr_b,
    output logic [M-2:0] twiddle_adr,
    output logic         we,
    output logic [M-1:0] wr_adr_a,
    output logic [M-1:0] wr_adr_b
);

    localparam int DW = $clog2(BF_LAT + 1);
    localparam int PW = 2 * M + 1;
    localparam logic [M-2:0]  I_LAST = (M-1)'(N / 2 - 1);
    localparam logic [M-1:0]  S_LAST = M'(M - 1);
    localparam logic [DW-1:0] D_INIT = DW'(BF_LAT);

    // bit_width only travels with the memories; it is checked here so it is not dangling.
    if (N != (1 << M) || N < 4 || BF_LAT < 1 || bit_width < 1) begin : g_param_check
        $error("fft_agu: inconsistent parameters");
    end

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FIN} state_t;

    state_t          state, state_nxt;
    logic [M-2:0]    idx, idx_nxt;
    logic [M-1:0]    s, s_nxt;
    logic [DW-1:0]   dcnt, dcnt_nxt;
    logic            bank, bank_nxt;
    logic            frz;
    logic            run;
    logic [M-2:0]    mask, low, tw;
    logic [M-1:0]    adr_a, adr_b;
    logic [PW-1:0]   dline [BF_LAT];
    logic            we_raw;

`ifdef FFT_AGU_STALL_EN
    assign frz = stall;
`else
    assign frz = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            idx   <= '0;
            s     <= '0;
            dcnt  <= '0;
            bank  <= 1'b0;
            for (int k = 0; k < BF_LAT; k++) dline[k] <= '0;
        end else if (!frz) begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            s        <= s_nxt;
            dcnt     <= dcnt_nxt;
            bank     <= bank_nxt;
            dline[0] <= {run, rd_adr_a, rd_adr_b};
            for (int k = 1; k < BF_LAT; k++) dline[k] <= dline[k-1];
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        s_nxt     = s;
        dcnt_nxt  = dcnt;
        bank_nxt  = bank;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_RUN;
                    idx_nxt   = '0;
                    s_nxt     = '0;
                    bank_nxt  = 1'b0;
                end
            end
            S_RUN: begin
                if (idx == I_LAST) begin
                    state_nxt = S_DRAIN;
                    dcnt_nxt  = D_INIT;
                end else begin
                    idx_nxt = idx + (M-1)'(1);
                end
            end
            S_DRAIN: begin
                if (dcnt == DW'(1)) begin
                    if (s < S_LAST) begin
                        state_nxt = S_RUN;
                        s_nxt     = s + M'(1);
                        idx_nxt   = '0;
                        bank_nxt  = ~bank;
                    end else begin
                        state_nxt = S_FIN;
                    end
                end else begin
                    dcnt_nxt = dcnt - DW'(1);
                end
            end
            S_FIN:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // The mask wraps to all-ones at s = M-1, which is exactly the full index width.
    assign mask  = ((M-1)'(1) << s) - (M-1)'(1);
    assign low   = idx & mask;
    assign tw    = low << (S_LAST - s);
    assign adr_a = (({1'b0, idx} >> s) << (s + M'(1))) | {1'b0, low};
    assign adr_b = adr_a | (M'(1) << s);

    // Addresses are held at zero outside RUN so reset and idle present all-zero outputs.
    assign run         = (state == S_RUN);
    assign rd_valid    = run & ~frz;
    assign rd_adr_a    = run ? adr_a : '0;
    assign rd_adr_b    = run ? adr_b : '0;
    assign twiddle_adr = run ? tw : '0;

    assign {we_raw, wr_adr_a, wr_adr_b} = dline[BF_LAT-1];
    assign we       = we_raw & ~frz;
    assign busy     = (state != S_IDLE);
    assign done     = (state == S_FIN);
    assign bank_sel = bank;
    assign stage    = s;

endmodule

// File: tb/tb_fft_agu.sv
// Randomized self-checking bench for fft_agu against a stage-timeline reference model.
// Define FFT_AGU_STALL_EN to exercise the stall port as well.
module tb_fft_agu;

    localparam int N      = 32;
    localparam int M      = 5;
    localparam int BF_LAT = 3;
    localparam int L      = N / 2 + BF_LAT;
    localparam int TLEN   = M * L + 1;
    localparam int MAXK   = 200;

    logic clk = 1'b0;
    logic reset_n, start;
`ifdef FFT_AGU_STALL_EN
    logic stall;
`endif
    logic busy, done, bank_sel, rd_valid, we;
    logic [M-1:0] stage, rd_adr_a, rd_adr_b, wr_adr_a, wr_adr_b;
    logic [M-2:0] twiddle_adr;

    typedef struct packed {
        logic         busy;
        logic         done;
        logic         bank_sel;
        logic [M-1:0] stage;
        logic         rd_valid;
        logic [M-1:0] rd_a;
        logic [M-1:0] rd_b;
        logic [M-2:0] tw;
        logic         we;
        logic [M-1:0] wr_a;
        logic [M-1:0] wr_b;
    } out_t;

    out_t obs_log   [MAXK+1];
    bit   stall_log [MAXK+1];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fft_agu #(.bit_width(16), .N(N), .M(M), .BF_LAT(BF_LAT)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .start(start),
`ifdef FFT_AGU_STALL_EN
        .stall(stall),
`endif
        .busy(busy),
        .done(done),
        .bank_sel(bank_sel),
        .stage(stage),
        .rd_valid(rd_valid),
        .rd_adr_a(rd_adr_a),
        .rd_adr_b(rd_adr_b),
        .twiddle_adr(twiddle_adr),
        .we(we),
        .wr_adr_a(wr_adr_a),
        .wr_adr_b(wr_adr_b)
    );

    function automatic out_t sample();
        sample = {busy, done, bank_sel, stage, rd_valid, rd_adr_a, rd_adr_b,
                  twiddle_adr, we, wr_adr_a, wr_adr_b};
    endfunction

    // Butterfly pos of stage st: group g of 2^(st+1) points, offset kk inside the group.
    function automatic void addr_of(input int st, input int pos, output logic [M-1:0] a,
                                    output logic [M-1:0] b, output logic [M-2:0] t);
        int half, g, kk;
        half = 1 << st;
        g    = pos / half;
        kk   = pos % half;
        a    = M'(g * 2 * half + kk);
        b    = M'(g * 2 * half + kk + half);
        t    = (M-1)'(kk * (N / (2 * half)));
    endfunction

    // Expected outputs (x) and which fields matter (m) for the e-th active cycle.
    function automatic void model(input int e, output out_t x, output out_t m);
        int st, pos, ew;
        logic [M-1:0] a, b;
        logic [M-2:0] t;
        x = '0;
        m = '0;
        m.busy = 1'b1; m.done = 1'b1; m.rd_valid = 1'b1; m.we = 1'b1;
        m.stage = '1; m.bank_sel = 1'b1;
        x.busy = 1'b1;
        if (e > M * L) begin
            x.done     = 1'b1;
            x.stage    = M'(M - 1);
            x.bank_sel = 1'((M - 1) % 2);
            return;
        end
        st = (e - 1) / L;
        pos = (e - 1) % L;
        x.stage    = M'(st);
        x.bank_sel = 1'(st % 2);
        if (pos < N / 2) begin
            addr_of(st, pos, a, b, t);
            x.rd_valid = 1'b1; x.rd_a = a; x.rd_b = b; x.tw = t;
            m.rd_a = '1; m.rd_b = '1; m.tw = '1;
        end
        ew = e - BF_LAT;
        if (ew >= 1) begin
            st = (ew - 1) / L;
            pos = (ew - 1) % L;
            if (pos < N / 2) begin
                addr_of(st, pos, a, b, t);
                x.we = 1'b1; x.wr_a = a; x.wr_b = b;
                m.wr_a = '1; m.wr_b = '1;
            end
        end
    endfunction

    // Start a transform from IDLE and log every cycle up to and including the done cycle.
    task automatic drive_transform(input bit noise, input int st_at, input int st_len, input bit hold);
        int last;
        last = TLEN + st_len;
        start = 1'b1;
        @(posedge clk); #1;
        for (int k = 1; k <= last; k++) begin
            if (k > 1) begin @(posedge clk); #1; end
            start = (k < last) ? (noise ? 1'($urandom_range(0, 1)) : 1'b0) : hold;
            stall_log[k] = (k >= st_at) && (k < st_at + st_len);
`ifdef FFT_AGU_STALL_EN
            stall = stall_log[k];
`endif
            @(negedge clk);
            obs_log[k] = sample();
        end
    endtask

    task automatic idle_gap();
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset();
        int n, bad;
        reset_n = 1'b0; start = 1'b0;
        #1;
        checks++;
        if (sample() !== '0) begin errors++; $display("FAIL reset_state got %h exp 0", sample()); end
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        n = 1 + int'($urandom_range(0, M - 1)) * L + int'($urandom_range(0, N / 2 - 1));
        repeat (n - 1) begin @(posedge clk); #1; end
        checks++;
        if (rd_valid !== 1'b1) begin errors++; $display("FAIL reset_mid_run_active cyc %0d got %b exp 1", n, rd_valid); end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (sample() !== '0) begin errors++; $display("FAIL reset_async got %h exp 0", sample()); end
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        bad = 0;
        repeat (120) begin @(negedge clk); if (done !== 1'b0 || busy !== 1'b0) bad++; end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL reset_no_done got %0d busy/done cycles exp 0", bad); end
    endtask

    task automatic test_stage_addresses();
        out_t x, m, o;
        int wes, toggles, firstwe;
        idle_gap();
        drive_transform(1'b0, 0, 0, 1'b0);
        for (int k = 1; k <= TLEN; k++) begin
            model(k, x, m);
            o = obs_log[k];
            checks++;
            if ((o & m) !== (x & m)) begin errors++; $display("FAIL seq_basic k=%0d got %h exp %h mask %h", k, o, x, m); end
        end
        checks++;
        if ({obs_log[1].rd_a, obs_log[1].rd_b, obs_log[1].tw} !== {5'd0, 5'd1, 4'd0}) begin
            errors++; $display("FAIL first_pair got %h exp %h", {obs_log[1].rd_a, obs_log[1].rd_b, obs_log[1].tw}, {5'd0, 5'd1, 4'd0});
        end
        checks++;
        if ({obs_log[6].rd_a, obs_log[6].rd_b} !== {5'd10, 5'd11}) begin
            errors++; $display("FAIL s0_i5 got %h exp %h", {obs_log[6].rd_a, obs_log[6].rd_b}, {5'd10, 5'd11});
        end
        checks++;
        if ({obs_log[1+2*L+5].rd_a, obs_log[1+2*L+5].rd_b, obs_log[1+2*L+5].tw} !== {5'd9, 5'd13, 4'd4}) begin
            errors++; $display("FAIL s2_i5 got %h exp %h", {obs_log[1+2*L+5].rd_a, obs_log[1+2*L+5].rd_b, obs_log[1+2*L+5].tw}, {5'd9, 5'd13, 4'd4});
        end
        checks++;
        if ({obs_log[1+4*L+15].rd_a, obs_log[1+4*L+15].rd_b, obs_log[1+4*L+15].tw} !== {5'd15, 5'd31, 4'd15}) begin
            errors++; $display("FAIL s4_i15 got %h exp %h", {obs_log[1+4*L+15].rd_a, obs_log[1+4*L+15].rd_b, obs_log[1+4*L+15].tw}, {5'd15, 5'd31, 4'd15});
        end
        wes = 0; toggles = 0; firstwe = 0;
        for (int k = 1; k <= TLEN; k++) begin
            if (obs_log[k].we) begin
                wes++;
                if (firstwe == 0) firstwe = k;
            end
            if (k > 1 && obs_log[k].bank_sel != obs_log[k-1].bank_sel) toggles++;
        end
        checks++;
        if (wes != M * N / 2) begin errors++; $display("FAIL we_count got %0d exp %0d", wes, M * N / 2); end
        checks++;
        if (firstwe != 1 + BF_LAT) begin errors++; $display("FAIL first_we_cycle got %0d exp %0d", firstwe, 1 + BF_LAT); end
        checks++;
        if ({obs_log[1+BF_LAT].wr_a, obs_log[1+BF_LAT].wr_b} !== {5'd0, 5'd1}) begin
            errors++; $display("FAIL first_wr_adr got %h exp %h", {obs_log[1+BF_LAT].wr_a, obs_log[1+BF_LAT].wr_b}, {5'd0, 5'd1});
        end
        checks++;
        if (toggles != M - 1) begin errors++; $display("FAIL bank_toggles got %0d exp %0d", toggles, M - 1); end
        checks++;
        if (obs_log[96].done !== 1'b1) begin errors++; $display("FAIL done_cycle96 got %b exp 1", obs_log[96].done); end
    endtask

    task automatic test_start_busy();
        out_t x, m, o;
        idle_gap();
        drive_transform(1'b1, 0, 0, 1'b0);
        for (int k = 1; k <= TLEN; k++) begin
            model(k, x, m);
            o = obs_log[k];
            checks++;
            if ((o & m) !== (x & m)) begin errors++; $display("FAIL seq_start_noise k=%0d got %h exp %h mask %h", k, o, x, m); end
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL idle_after_noise got busy=%b exp 0", busy); end
    endtask

    task automatic test_back_to_back();
        out_t x, m, o;
        idle_gap();
        for (int r = 0; r < 2; r++) begin
            drive_transform(1'b0, 0, 0, r == 0);
            for (int k = 1; k <= TLEN; k++) begin
                model(k, x, m);
                o = obs_log[k];
                checks++;
                if ((o & m) !== (x & m)) begin errors++; $display("FAIL seq_b2b run=%0d k=%0d got %h exp %h mask %h", r, k, o, x, m); end
            end
            if (r == 0) begin
                @(posedge clk); #1;
                @(negedge clk);
                checks++;
                if ({busy, done} !== 2'b00) begin errors++; $display("FAIL b2b_idle_gap got %b exp 00", {busy, done}); end
            end
        end
        start = 1'b0;
    endtask

`ifdef FFT_AGU_STALL_EN
    task automatic test_stall();
        out_t x, m, o;
        int e, at, len;
        for (int r = 0; r < 3; r++) begin
            at  = (r == 0) ? 1 + L + 8 : int'($urandom_range(1, M * L));
            len = (r == 0) ? 7 : int'($urandom_range(1, 6));
            idle_gap();
            drive_transform(1'b0, at, len, 1'b0);
            e = 1;
            for (int k = 1; k <= TLEN + len; k++) begin
                model(e, x, m);
                if (stall_log[k]) begin
                    x.rd_valid = 1'b0; x.we = 1'b0; m.wr_a = '0; m.wr_b = '0;
                end
                o = obs_log[k];
                checks++;
                if ((o & m) !== (x & m)) begin errors++; $display("FAIL seq_stall at=%0d len=%0d k=%0d got %h exp %h mask %h", at, len, k, o, x, m); end
                if (!stall_log[k]) e++;
            end
            checks++;
            if (obs_log[TLEN + len].done !== 1'b1) begin errors++; $display("FAIL stall_done_cycle %0d got %b exp 1", TLEN + len, obs_log[TLEN + len].done); end
        end
    endtask
`endif

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
`ifdef FFT_AGU_STALL_EN
        stall   = 1'b0;
`endif
        test_reset();
        test_stage_addresses();
        test_start_busy();
        test_back_to_back();
`ifdef FFT_AGU_STALL_EN
        test_stall();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
